// File: rtl/hls_bridge_pkg.sv
// Shared definitions for the CPU-to-HLS multi-channel bridge.
//
// Contents:
//   clog2        - ceiling log2, usable in parameter/port declarations
//   cmd_width    - width of one packed command word
//   cmd_off_*    - bit offsets of the fields inside a packed command word
//                  {last,size,uncached,write,mask,data,address}, address in LSBs
//   rsp_width    - width of one packed response beat {last,data}
//   rsp_off_last - bit offset of the last flag inside a response beat
package hls_bridge_pkg;

  localparam int MASK_W     = 4;
  localparam int SIZE_W     = 3;
  // last + size + uncached + write + mask
  localparam int CMD_CTRL_W = 1 + SIZE_W + 1 + 1 + MASK_W;

  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

  function automatic int cmd_width(input int aw, input int dw);
    return aw + dw + CMD_CTRL_W;
  endfunction

  function automatic int cmd_off_data(input int aw);
    return aw;
  endfunction

  function automatic int cmd_off_mask(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int cmd_off_write(input int aw, input int dw);
    return aw + dw + MASK_W;
  endfunction

  function automatic int cmd_off_uncached(input int aw, input int dw);
    return aw + dw + MASK_W + 1;
  endfunction

  function automatic int cmd_off_size(input int aw, input int dw);
    return aw + dw + MASK_W + 2;
  endfunction

  function automatic int cmd_off_last(input int aw, input int dw);
    return aw + dw + MASK_W + 2 + SIZE_W;
  endfunction

  function automatic int rsp_width(input int dw);
    return dw + 1;
  endfunction

  function automatic int rsp_off_last(input int dw);
    return dw;
  endfunction

endpackage

// File: rtl/hls_tag_fifo.sv
// Outstanding-read tag FIFO: remembers which channel each accepted read went
// to, so responses can be collected strictly in command order.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (empties the FIFO)
//   push       - write push_data (ignored when full)
//   push_data  - channel index of the accepted read
//   pop        - retire the head entry (ignored when empty)
//   head       - current head entry, combinational from storage
//   full/empty - occupancy flags
// Push and pop in the same cycle are both honoured.
module hls_tag_fifo
  import hls_bridge_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
  localparam int CNT_W = clog2(DEPTH) + 1;

  // Head must be visible in the same cycle to steer the response pop, so the
  // storage is read asynchronously; at this depth it maps to registers.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr_reg];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= next_ptr(wr_ptr_reg);
      end
      if (pop_ok) begin
        rd_ptr_reg <= next_ptr(rd_ptr_reg);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/hls_bridge_mux.sv
// CPU data-bus to NUM_CH HLS kernels bridge.
//
// Commands are steered combinationally to the kernel selected by
// address[CH_SEL_LSB +: CH_W]; read responses are collected in command order
// via an outstanding-tag FIFO and registered onto the bus (1-cycle latency).
//
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   io_bus_cmd_valid/ready      - bus command handshake
//   io_bus_cmd_payload_*        - address, data, mask, write, uncached, size, last
//   io_bus_rsp_valid            - response beat strobe (no backpressure)
//   io_bus_rsp_payload_data/last- response beat
//   ch_cmd_din                  - packed command, same payload on every channel
//   ch_cmd_full_n/ch_cmd_write  - per-channel command FIFO not-full / one-hot push
//   ch_rsp_dout                 - packed {last,data} per channel
//   ch_rsp_empty_n/ch_rsp_read  - per-channel response FIFO not-empty / one-hot pop
//   busy                        - reads outstanding or a response beat pending
module hls_bridge_mux
  import hls_bridge_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int NUM_CH          = 4,
  parameter int CH_SEL_LSB      = 24,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STRIP_MSB       = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        io_bus_cmd_valid,
  output logic                        io_bus_cmd_ready,
  input  logic [DATA_ADDR_WIDTH-1:0]  io_bus_cmd_payload_address,
  input  logic [DATA_WIDTH-1:0]       io_bus_cmd_payload_data,
  input  logic [3:0]                  io_bus_cmd_payload_mask,
  input  logic                        io_bus_cmd_payload_write,
  input  logic                        io_bus_cmd_payload_uncached,
  input  logic [2:0]                  io_bus_cmd_payload_size,
  input  logic                        io_bus_cmd_payload_last,
  output logic                        io_bus_rsp_valid,
  output logic [DATA_WIDTH-1:0]       io_bus_rsp_payload_data,
  output logic                        io_bus_rsp_payload_last,
  output logic [NUM_CH*cmd_width(DATA_ADDR_WIDTH, DATA_WIDTH)-1:0] ch_cmd_din,
  input  logic [NUM_CH-1:0]           ch_cmd_full_n,
  output logic [NUM_CH-1:0]           ch_cmd_write,
  input  logic [NUM_CH*(DATA_WIDTH+1)-1:0] ch_rsp_dout,
  input  logic [NUM_CH-1:0]           ch_rsp_empty_n,
  output logic [NUM_CH-1:0]           ch_rsp_read,
  output logic                        busy
);

  localparam int CH_W  = clog2(NUM_CH);
  localparam int CMD_W = cmd_width(DATA_ADDR_WIDTH, DATA_WIDTH);
  localparam int RSP_W = rsp_width(DATA_WIDTH);

  logic [CH_W-1:0]            sel;
  logic [DATA_ADDR_WIDTH-1:0] fwd_address;
  logic [CMD_W-1:0]           cmd_word;
  logic                       cmd_fire;

  logic                       tag_push;
  logic                       tag_pop;
  logic [CH_W-1:0]            tag_head;
  logic                       tag_full;
  logic                       tag_empty;

  logic [RSP_W-1:0]           rsp_beat [NUM_CH];
  logic [RSP_W-1:0]           head_beat;
  logic                       rsp_fire;

  logic                       rsp_valid_reg;
  logic [DATA_WIDTH-1:0]      rsp_data_reg;
  logic                       rsp_last_reg;

  // ---------------------------------------------------------------- command
  assign sel = io_bus_cmd_payload_address[CH_SEL_LSB +: CH_W];

  always_comb begin
    fwd_address = io_bus_cmd_payload_address;
    if (STRIP_MSB != 0) begin
      fwd_address[DATA_ADDR_WIDTH-1] = 1'b0;
    end
  end

  assign cmd_word = {io_bus_cmd_payload_last,
                     io_bus_cmd_payload_size,
                     io_bus_cmd_payload_uncached,
                     io_bus_cmd_payload_write,
                     io_bus_cmd_payload_mask,
                     io_bus_cmd_payload_data,
                     fwd_address};

  // Reads also need a free tag slot; writes only need the kernel's FIFO.
  assign io_bus_cmd_ready = ~rst & ch_cmd_full_n[sel]
                          & (io_bus_cmd_payload_write | ~tag_full);
  assign cmd_fire         = io_bus_cmd_valid & io_bus_cmd_ready;
  assign tag_push         = cmd_fire & ~io_bus_cmd_payload_write;

  // --------------------------------------------------------------- tag FIFO
  hls_tag_fifo #(
    .WIDTH (CH_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_push),
    .push_data (sel),
    .pop       (tag_pop),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  // ------------------------------------------------------ per-channel fanout
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_cmd_din[gi*CMD_W +: CMD_W] = cmd_word;
      assign ch_cmd_write[gi] = cmd_fire & (sel == CH_W'(gi));
      assign rsp_beat[gi]     = ch_rsp_dout[gi*RSP_W +: RSP_W];
      // Only the channel owning the oldest outstanding read is ever popped.
      assign ch_rsp_read[gi]  = rsp_fire & (tag_head == CH_W'(gi));
    end
  endgenerate

  // --------------------------------------------------------------- response
  assign head_beat = rsp_beat[tag_head];
  assign rsp_fire  = ~rst & ~tag_empty & ch_rsp_empty_n[tag_head];
  // A multi-beat refill keeps its tag until the beat flagged last.
  assign tag_pop   = rsp_fire & head_beat[rsp_off_last(DATA_WIDTH)];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_last_reg  <= 1'b0;
    end else begin
      rsp_valid_reg <= rsp_fire;
      rsp_last_reg  <= rsp_fire & head_beat[rsp_off_last(DATA_WIDTH)];
      if (rsp_fire) begin
        rsp_data_reg <= head_beat[DATA_WIDTH-1:0];
      end
    end
  end

  assign io_bus_rsp_valid        = rsp_valid_reg;
  assign io_bus_rsp_payload_data = rsp_data_reg;
  assign io_bus_rsp_payload_last = rsp_last_reg;
  assign busy                    = ~tag_empty | rsp_valid_reg;

endmodule

// File: tb/tb_hls_bridge_mux.sv
module tb_hls_bridge_mux;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NC = 4;
  localparam int CW = AW + DW + 10;
  localparam int RW = DW + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [AW-1:0]      cmd_addr;
  logic [DW-1:0]      cmd_data;
  logic [3:0]         cmd_mask;
  logic               cmd_write;
  logic               cmd_uncached;
  logic [2:0]         cmd_size;
  logic               cmd_last;
  logic               rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               rsp_last;
  logic [NC*CW-1:0]   ch_cmd_din;
  logic [NC-1:0]      ch_cmd_full_n;
  logic [NC-1:0]      ch_cmd_write;
  logic [NC*RW-1:0]   ch_rsp_dout;
  logic [NC-1:0]      ch_rsp_empty_n;
  logic [NC-1:0]      ch_rsp_read;
  logic               busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hls_bridge_mux dut (
    .clk                         (clk),
    .rst                         (rst),
    .io_bus_cmd_valid            (cmd_valid),
    .io_bus_cmd_ready            (cmd_ready),
    .io_bus_cmd_payload_address  (cmd_addr),
    .io_bus_cmd_payload_data     (cmd_data),
    .io_bus_cmd_payload_mask     (cmd_mask),
    .io_bus_cmd_payload_write    (cmd_write),
    .io_bus_cmd_payload_uncached (cmd_uncached),
    .io_bus_cmd_payload_size     (cmd_size),
    .io_bus_cmd_payload_last     (cmd_last),
    .io_bus_rsp_valid            (rsp_valid),
    .io_bus_rsp_payload_data     (rsp_data),
    .io_bus_rsp_payload_last     (rsp_last),
    .ch_cmd_din                  (ch_cmd_din),
    .ch_cmd_full_n               (ch_cmd_full_n),
    .ch_cmd_write                (ch_cmd_write),
    .ch_rsp_dout                 (ch_rsp_dout),
    .ch_rsp_empty_n              (ch_rsp_empty_n),
    .ch_rsp_read                 (ch_rsp_read),
    .busy                        (busy)
  );

  // Kernel response FIFO model: 16-entry ring per channel, popped on ch_rsp_read.
  logic [RW-1:0] kmem [NC][16];
  int kwp [NC] = '{0, 0, 0, 0};
  int krp [NC] = '{0, 0, 0, 0};

  generate
    for (genvar gi = 0; gi < NC; gi++) begin : g_k
      assign ch_rsp_empty_n[gi]       = (kwp[gi] != krp[gi]);
      assign ch_rsp_dout[gi*RW +: RW] = kmem[gi][krp[gi][3:0]];
    end
  endgenerate

  always @(posedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (ch_rsp_read[c] && kwp[c] != krp[c]) krp[c] <= krp[c] + 1;
    end
  end

  task automatic push_beat(input int c, input logic last, input logic [DW-1:0] d);
    kmem[c][kwp[c][3:0]] = {last, d};
    kwp[c] = kwp[c] + 1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  // Drive a command at the falling edge and check it is accepted.
  task automatic issue(input logic [AW-1:0] a, input logic w, input string nm);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_write = w;
    #1;
    chk(nm, cmd_ready, 1'b1);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [NC-1:0] full_n;
    logic [DW-1:0] data;
    logic          exp_ready;
    logic [NC-1:0] exp_wr;
    logic [AW-1:0] exp_fwd;
  } vec_t;

  vec_t vt [8];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{32'h8200_0010, 1'b1, 4'hF,    32'hDEAD_BEEF, 1'b1, 4'b0100, 32'h0200_0010};
    vt[1] = '{32'h0100_0000, 1'b0, 4'hF,    32'h0000_0001, 1'b1, 4'b0010, 32'h0100_0000};
    vt[2] = '{32'hFF00_0004, 1'b0, 4'hF,    32'h0000_0002, 1'b1, 4'b1000, 32'h7F00_0004};
    vt[3] = '{32'h0100_0000, 1'b1, 4'b1101, 32'h0000_0003, 1'b0, 4'b0000, 32'h0100_0000};
    vt[4] = '{32'h0000_0040, 1'b1, 4'b1101, 32'h0000_0004, 1'b1, 4'b0001, 32'h0000_0040};
    vt[5] = '{32'h8300_0000, 1'b0, 4'b0111, 32'h0000_0005, 1'b0, 4'b0000, 32'h0300_0000};
    vt[6] = '{32'h0600_0000, 1'b0, 4'hF,    32'h0000_0006, 1'b1, 4'b0100, 32'h0600_0000};
    vt[7] = '{32'h80FF_FFFF, 1'b1, 4'hF,    32'h1234_5678, 1'b1, 4'b0001, 32'h00FF_FFFF};

    rst           = 1'b1;
    cmd_valid     = 1'b1;
    cmd_addr      = 32'h8200_0010;
    cmd_data      = 32'hDEAD_BEEF;
    cmd_mask      = 4'hF;
    cmd_write     = 1'b1;
    cmd_uncached  = 1'b0;
    cmd_size      = 3'd2;
    cmd_last      = 1'b1;
    ch_cmd_full_n = 4'hF;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_last", rsp_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_cmd_write", ch_cmd_write, 4'h0);
    chk("rst_rsp_read", ch_rsp_read, 4'h0);
    @(negedge clk);
    rst       = 1'b0;
    cmd_valid = 1'b0;

    // Combinational command-path vectors (valid dropped before the next edge)
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cmd_addr      = vt[i].addr;
      cmd_write     = vt[i].write;
      cmd_data      = vt[i].data;
      ch_cmd_full_n = vt[i].full_n;
      cmd_valid     = 1'b1;
      #1;
      chk($sformatf("vec%0d_ready", i), cmd_ready, vt[i].exp_ready);
      chk($sformatf("vec%0d_write", i), ch_cmd_write, vt[i].exp_wr);
      chk($sformatf("vec%0d_fwd_addr", i), ch_cmd_din[AW-1:0], vt[i].exp_fwd);
      chk($sformatf("vec%0d_din_ch3", i), ch_cmd_din[3*CW +: CW],
          {1'b1, 3'd2, 1'b0, vt[i].write, 4'hF, vt[i].data, vt[i].exp_fwd});
      cmd_valid = 1'b0;
    end
    ch_cmd_full_n = 4'hF;

    // Clocked write: no response, busy stays low
    @(negedge clk);
    cmd_addr  = 32'h8200_0010;
    cmd_data  = 32'hDEAD_BEEF;
    cmd_write = 1'b1;
    cmd_valid = 1'b1;
    #1;
    chk("wr_ch2_strobe", ch_cmd_write, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      chk($sformatf("wr_no_rsp%0d", k), {busy, rsp_valid}, 2'b00);
    end

    // In-order responses: ch1 then ch0, ch0 data ready first
    issue(32'h0100_0000, 1'b0, "ord_rd_ch1_ready");
    issue(32'h0000_0000, 1'b0, "ord_rd_ch0_ready");
    @(negedge clk);
    cmd_valid = 1'b0;
    push_beat(0, 1'b1, 32'hC0C0_0000);
    #1;
    chk("ord_hold_ch0", ch_rsp_read, 4'h0);
    chk("ord_busy", busy, 1'b1);
    @(negedge clk);
    #1;
    chk("ord_hold_ch0_again", ch_rsp_read, 4'h0);
    chk("ord_no_rsp", rsp_valid, 1'b0);
    push_beat(1, 1'b1, 32'h1111_1111);
    #1;
    chk("ord_read_ch1", ch_rsp_read, 4'b0010);
    @(negedge clk);
    #1;
    chk("ord_rsp1", {rsp_valid, rsp_last, rsp_data}, {2'b11, 32'h1111_1111});
    chk("ord_read_ch0", ch_rsp_read, 4'b0001);
    @(negedge clk);
    #1;
    chk("ord_rsp0", {rsp_valid, rsp_last, rsp_data}, {2'b11, 32'hC0C0_0000});
    @(negedge clk);
    #1;
    chk("ord_idle", {busy, rsp_valid}, 2'b00);

    // 8-beat refill on ch3, beats pre-filled
    for (int i = 0; i < 8; i++) push_beat(3, (i == 7), 32'h3000_0000 + i);
    issue(32'h0300_0000, 1'b0, "burst_ready");
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      chk($sformatf("burst_read%0d", k), ch_rsp_read, (k < 8) ? 4'b1000 : 4'b0000);
      if (k == 0) begin
        chk("burst_first_no_rsp", rsp_valid, 1'b0);
      end else begin
        chk($sformatf("burst_beat%0d", k), {rsp_valid, rsp_last, rsp_data},
            {1'b1, (k == 8), 32'h3000_0000 + k - 1});
      end
    end
    @(negedge clk);
    #1;
    chk("burst_idle", {busy, rsp_valid}, 2'b00);

    // Tag FIFO full: reads stall, writes pass, ready returns after first pop
    for (int j = 0; j < 4; j++) issue(32'h0200_0000, 1'b0, $sformatf("fill%0d_ready", j));
    @(negedge clk);
    cmd_addr  = 32'h0000_0000;
    cmd_write = 1'b0;
    #1;
    chk("full_rd_ready", cmd_ready, 1'b0);
    chk("full_rd_strobe", ch_cmd_write, 4'h0);
    cmd_addr  = 32'h0100_0000;
    cmd_write = 1'b1;
    #1;
    chk("full_wr_ready", cmd_ready, 1'b1);
    chk("full_wr_strobe", ch_cmd_write, 4'b0010);
    @(negedge clk);
    cmd_addr  = 32'h0000_0000;
    cmd_write = 1'b0;
    push_beat(2, 1'b1, 32'h2222_0001);
    #1;
    chk("full_pop_cycle_ready", cmd_ready, 1'b0);
    chk("full_pop_read", ch_rsp_read, 4'b0100);
    @(negedge clk);
    #1;
    chk("full_ready_after_pop", cmd_ready, 1'b1);
    chk("full_rsp", {rsp_valid, rsp_data}, {1'b1, 32'h2222_0001});
    cmd_valid = 1'b0;
    for (int j = 2; j <= 4; j++) push_beat(2, 1'b1, 32'h2222_0000 + j);
    begin
      int cyc = 0;
      while (busy && cyc < 30) begin
        @(negedge clk);
        cyc++;
      end
      chk("full_drain_busy", busy, 1'b0);
    end

    // Reset with 2 tags outstanding and a response beat on the bus
    issue(32'h0000_0000, 1'b0, "rr_rd0_ready");
    issue(32'h0100_0000, 1'b0, "rr_rd1_ready");
    issue(32'h0100_0000, 1'b0, "rr_rd2_ready");
    @(negedge clk);
    cmd_valid = 1'b0;
    push_beat(0, 1'b1, 32'hAAAA_0000);
    @(negedge clk);
    #1;
    chk("rr_pre_rsp", {rsp_valid, busy, rsp_data}, {2'b11, 32'hAAAA_0000});
    cmd_addr  = 32'h0200_0000;
    cmd_write = 1'b0;
    cmd_valid = 1'b1;
    rst       = 1'b1;
    #1;
    chk("rr_rsp_cleared", {rsp_valid, rsp_last, rsp_data}, {2'b00, 32'h0});
    chk("rr_busy", busy, 1'b0);
    chk("rr_ready", cmd_ready, 1'b0);
    chk("rr_cmd_write", ch_cmd_write, 4'h0);
    @(negedge clk);
    rst       = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("rr_after_busy", busy, 1'b0);
    push_beat(1, 1'b1, 32'hDEAD_0001);
    #1;
    chk("rr_no_stale_read", ch_rsp_read, 4'h0);
    push_beat(3, 1'b1, 32'h3333_3333);
    issue(32'h0300_0000, 1'b0, "rr_post_ready");
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("rr_post_read", ch_rsp_read, 4'b1000);
    @(negedge clk);
    #1;
    chk("rr_post_rsp", {rsp_valid, rsp_last, rsp_data}, {2'b11, 32'h3333_3333});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
